// File: rtl/regfile_wr_arbiter_if.sv
// Writeback bus for regfile_wr_arbiter: pipeline request, multi-cycle result
// push, registered register-file write port and FIFO occupancy.
interface regfile_wr_arbiter_if #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 2
);
  logic                     pipe_we_i;
  logic [4:0]               pipe_rd_i;
  logic [DWIDTH-1:0]        pipe_data_i;
  logic                     pipe_stall_o;
  logic                     mc_valid_i;
  logic [4:0]               mc_rd_i;
  logic [DWIDTH-1:0]        mc_data_i;
  logic                     mc_ready_o;
  logic                     rf_we_o;
  logic [4:0]               rf_rd_o;
  logic [DWIDTH-1:0]        rf_data_o;
  logic [$clog2(DEPTH):0]   fifo_count_o;

  modport master (
    output pipe_we_i, pipe_rd_i, pipe_data_i, mc_valid_i, mc_rd_i, mc_data_i,
    input  pipe_stall_o, mc_ready_o, rf_we_o, rf_rd_o, rf_data_o, fifo_count_o
  );

  modport slave (
    input  pipe_we_i, pipe_rd_i, pipe_data_i, mc_valid_i, mc_rd_i, mc_data_i,
    output pipe_stall_o, mc_ready_o, rf_we_o, rf_rd_o, rf_data_o, fifo_count_o
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates one register-file write port between the pipeline writeback stage
// and a FIFO of multi-cycle results, with bounded starvation of the FIFO head.
module regfile_wr_arbiter #(
  parameter int DWIDTH     = 32,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_wr_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  typedef struct packed {
    logic [4:0]        rd;
    logic [DWIDTH-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve_cnt;
  logic            pipe_req;
  logic            fifo_req;
  logic            fifo_gnt;
  logic            pipe_gnt;
  logic            push;
  logic            pop;

  always_comb begin
    head     = mem[rd_ptr];
    pipe_req = bus.pipe_we_i && (bus.pipe_rd_i != 5'd0);
    fifo_req = (count != '0);
    fifo_gnt = fifo_req && (!pipe_req || (starve_cnt == STARVE_C));
    pipe_gnt = pipe_req && !fifo_gnt;
    pop      = fifo_gnt;
    // Ready comes from the registered count only, so a full FIFO never accepts
    // on the same edge it pops.
    push     = bus.mc_valid_i && (count < DEPTH_C);
  end

  assign bus.mc_ready_o   = (count < DEPTH_C);
  assign bus.pipe_stall_o = pipe_req && fifo_gnt;
  assign bus.fifo_count_o = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{rd: bus.mc_rd_i, data: bus.mc_data_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop || !fifo_req) begin
        starve_cnt <= '0;
      end else if (pipe_gnt && (starve_cnt != STARVE_C)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // An x0 head is consumed by the grant but never reaches the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rf_we_o   <= 1'b0;
      bus.rf_rd_o   <= '0;
      bus.rf_data_o <= '0;
    end else if (pipe_gnt) begin
      bus.rf_we_o   <= 1'b1;
      bus.rf_rd_o   <= bus.pipe_rd_i;
      bus.rf_data_o <= bus.pipe_data_i;
    end else if (fifo_gnt && (head.rd != 5'd0)) begin
      bus.rf_we_o   <= 1'b1;
      bus.rf_rd_o   <= head.rd;
      bus.rf_data_o <= head.data;
    end else begin
      bus.rf_we_o   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with DEPTH=2, STARVE_MAX=4.
module tb_regfile_wr_arbiter;
  localparam int DWIDTH = 32;
  localparam int DEPTH  = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  regfile_wr_arbiter_if #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) bus ();

  regfile_wr_arbiter #(
    .DWIDTH     (DWIDTH),
    .DEPTH      (DEPTH),
    .STARVE_MAX (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rf_expect(input string tag, input logic we, input logic [4:0] rd,
                           input logic [31:0] data);
    check({tag, ".we"}, 64'(bus.rf_we_o), 64'(we));
    check({tag, ".rd"}, 64'(bus.rf_rd_o), 64'(rd));
    check({tag, ".data"}, 64'(bus.rf_data_o), 64'(data));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    bus.pipe_we_i = 1'b0; bus.pipe_rd_i = '0; bus.pipe_data_i = '0;
    bus.mc_valid_i = 1'b0; bus.mc_rd_i = '0; bus.mc_data_i = '0;
    #3;
    rf_expect("reset", 1'b0, 5'd0, 32'h0);
    check("reset.count", 64'(bus.fifo_count_o), 64'd0);
    check("reset.ready", 64'(bus.mc_ready_o), 64'd1);
    check("reset.stall", 64'(bus.pipe_stall_o), 64'd0);
    #9 rst_n = 1'b1;
    tick();

    // pipeline write, FIFO empty
    bus.pipe_we_i = 1'b1; bus.pipe_rd_i = 5'd5; bus.pipe_data_i = 32'hA5A5A5A5;
    #1 check("pipe.stall", 64'(bus.pipe_stall_o), 64'd0);
    tick();
    rf_expect("pipe", 1'b1, 5'd5, 32'hA5A5A5A5);
    bus.pipe_we_i = 1'b0;
    tick();
    rf_expect("idle_hold", 1'b0, 5'd5, 32'hA5A5A5A5);

    // single multi-cycle push with pipeline idle
    bus.mc_valid_i = 1'b1; bus.mc_rd_i = 5'd7; bus.mc_data_i = 32'h1234;
    tick();
    bus.mc_valid_i = 1'b0;
    check("mc.count1", 64'(bus.fifo_count_o), 64'd1);
    tick();
    rf_expect("mc", 1'b1, 5'd7, 32'h1234);
    check("mc.count0", 64'(bus.fifo_count_o), 64'd0);

    // starvation: FIFO holds rd=9 while pipeline writes every cycle
    bus.pipe_we_i = 1'b1; bus.pipe_rd_i = 5'd3; bus.pipe_data_i = 32'h30;
    bus.mc_valid_i = 1'b1; bus.mc_rd_i = 5'd9; bus.mc_data_i = 32'h99;
    tick();
    bus.mc_valid_i = 1'b0;
    rf_expect("starve.p0", 1'b1, 5'd3, 32'h30);
    for (int i = 0; i < 4; i++) begin
      bus.pipe_rd_i = 5'(10 + i); bus.pipe_data_i = 32'h100 + 32'(i);
      #1 check($sformatf("starve.stall%0d", i), 64'(bus.pipe_stall_o), 64'd0);
      tick();
      rf_expect($sformatf("starve.win%0d", i), 1'b1, 5'(10 + i), 32'h100 + 32'(i));
    end
    bus.pipe_rd_i = 5'd20; bus.pipe_data_i = 32'h200;
    #1 check("starve.stall", 64'(bus.pipe_stall_o), 64'd1);
    tick();
    rf_expect("starve.fifo", 1'b1, 5'd9, 32'h99);
    check("starve.count", 64'(bus.fifo_count_o), 64'd0);
    check("starve.unstall", 64'(bus.pipe_stall_o), 64'd0);
    tick();
    rf_expect("starve.pipe", 1'b1, 5'd20, 32'h200);

    // fill DEPTH=2 FIFO while pipeline busy, third result held until a pop
    bus.pipe_rd_i = 5'd1; bus.pipe_data_i = 32'h1;
    bus.mc_valid_i = 1'b1; bus.mc_rd_i = 5'd11; bus.mc_data_i = 32'h1111;
    tick();
    check("full.count1", 64'(bus.fifo_count_o), 64'd1);
    bus.mc_rd_i = 5'd12; bus.mc_data_i = 32'h1212;
    #1 check("full.ready1", 64'(bus.mc_ready_o), 64'd1);
    tick();
    check("full.count2", 64'(bus.fifo_count_o), 64'd2);
    bus.mc_rd_i = 5'd13; bus.mc_data_i = 32'h1313;
    #1 check("full.ready0", 64'(bus.mc_ready_o), 64'd0);
    tick();
    check("full.held", 64'(bus.fifo_count_o), 64'd2);
    rf_expect("full.pipe", 1'b1, 5'd1, 32'h1);
    bus.pipe_we_i = 1'b0;
    tick();
    rf_expect("full.pop11", 1'b1, 5'd11, 32'h1111);
    check("full.count_a", 64'(bus.fifo_count_o), 64'd1);
    check("full.ready_a", 64'(bus.mc_ready_o), 64'd1);
    tick();
    bus.mc_valid_i = 1'b0;
    rf_expect("full.pop12", 1'b1, 5'd12, 32'h1212);
    check("full.count_b", 64'(bus.fifo_count_o), 64'd1);
    tick();
    rf_expect("full.pop13", 1'b1, 5'd13, 32'h1313);
    check("full.count_c", 64'(bus.fifo_count_o), 64'd0);

    // x0 on both sources: head dropped, nothing written
    bus.mc_valid_i = 1'b1; bus.mc_rd_i = 5'd0; bus.mc_data_i = 32'hBAD0;
    tick();
    bus.mc_valid_i = 1'b0;
    check("x0.count1", 64'(bus.fifo_count_o), 64'd1);
    bus.pipe_we_i = 1'b1; bus.pipe_rd_i = 5'd0; bus.pipe_data_i = 32'hDEAD;
    #1 check("x0.stall", 64'(bus.pipe_stall_o), 64'd0);
    tick();
    rf_expect("x0", 1'b0, 5'd13, 32'h1313);
    check("x0.count0", 64'(bus.fifo_count_o), 64'd0);

    // reset mid-stream with FIFO full
    bus.pipe_rd_i = 5'd2; bus.pipe_data_i = 32'h2;
    bus.mc_valid_i = 1'b1; bus.mc_rd_i = 5'd14; bus.mc_data_i = 32'h1414;
    tick();
    bus.mc_rd_i = 5'd15; bus.mc_data_i = 32'h1515;
    tick();
    check("rst.precount", 64'(bus.fifo_count_o), 64'd2);
    check("rst.prewe", 64'(bus.rf_we_o), 64'd1);
    rst_n = 1'b0;
    #1;
    rf_expect("rst.async", 1'b0, 5'd0, 32'h0);
    check("rst.count", 64'(bus.fifo_count_o), 64'd0);
    check("rst.ready", 64'(bus.mc_ready_o), 64'd1);
    check("rst.stall", 64'(bus.pipe_stall_o), 64'd0);
    bus.pipe_we_i = 1'b0; bus.mc_valid_i = 1'b0;
    tick();
    check("rst.held_we", 64'(bus.rf_we_o), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst.after_we%0d", i), 64'(bus.rf_we_o), 64'd0);
      check($sformatf("rst.after_cnt%0d", i), 64'(bus.fifo_count_o), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, register data width.
REQ-002 SHALL have parameter DEPTH, default 2, multi-cycle result FIFO depth (power of 2, >=2).
REQ-003 SHALL have parameter STARVE_MAX, default 4, max consecutive cycles the FIFO head may lose arbitration.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port pipe_we_i  input  1  pipeline writeback stage requests a register write.
REQ-007 SHALL have port pipe_rd_i  input  5  pipeline destination register.
REQ-008 SHALL have port pipe_data_i  input  DWIDTH  pipeline writeback data.
REQ-009 SHALL have port pipe_stall_o  output  1  pipeline write not accepted this cycle; hold pipe_* stable.
REQ-010 SHALL have port mc_valid_i  input  1  multi-cycle unit result valid.
REQ-011 SHALL have port mc_rd_i  input  5  multi-cycle result destination register.
REQ-012 SHALL have port mc_data_i  input  DWIDTH  multi-cycle result data.
REQ-013 SHALL have port mc_ready_o  output  1  FIFO can accept a result.
REQ-014 SHALL have port rf_we_o  output  1  register file write enable (registered).
REQ-015 SHALL have port rf_rd_o  output  5  register file write address (registered).
REQ-016 SHALL have port rf_data_o  output  DWIDTH  register file write data (registered).
REQ-017 SHALL have port fifo_count_o  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-018 SHALL accept a multi-cycle result on a rising edge where mc_valid_i && mc_ready_o, pushing {rd,data} to the FIFO tail.
REQ-019 SHALL drive mc_ready_o = (fifo_count_o < DEPTH), combinationally from registered count only; no same-cycle pop credit.
REQ-020 SHALL treat a request as live: pipe_req = pipe_we_i && pipe_rd_i != 0; fifo_req = count > 0.
REQ-021 SHALL drop x0 FIFO entries: head with rd==0 is popped without asserting rf_we_o.
REQ-022 SHALL keep a starvation counter: increments each cycle fifo_req && pipe_req && pipe wins; clears on FIFO pop or when FIFO empty; saturates at STARVE_MAX.
REQ-023 SHALL grant, each cycle: FIFO if fifo_req && (!pipe_req || starve_cnt == STARVE_MAX); else pipe if pipe_req; else none.
REQ-024 SHALL assert pipe_stall_o combinationally iff pipe_req && FIFO granted; never otherwise.
REQ-025 SHALL register the granted write: at the edge, rf_we_o<=1, rf_rd_o/rf_data_o <= winner's rd/data; with no grant rf_we_o<=0, rf_rd_o/rf_data_o hold.
REQ-026 SHALL give latency: pipe write visible on rf_* one cycle after its request cycle; FIFO entry pushed at edge N is earliest written at edge N+1 (rf_we_o high cycle N+1 to N+2).
REQ-027 SHALL pop the FIFO head on the edge where it is granted; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-028 SHALL wrap FIFO read/write pointers modulo DEPTH; count never exceeds DEPTH nor underflows.
REQ-029 SHALL not resolve same-rd ordering between sources; pipeline scoreboard guarantees no overlap.

Reset
REQ-030 SHALL on rst_n low, asynchronously: rf_we_o=0, rf_rd_o=0, rf_data_o=0, FIFO empty (count 0, pointers 0), starve_cnt=0; pipe_stall_o=0, mc_ready_o=1 thereafter while reset held.
REQ-031 SHALL discard FIFO contents on reset mid-operation; no write issued from pre-reset entries after release.
REQ-032 SHALL resume arbitration on the first rising edge after rst_n deasserts.

Verification
REQ-033 SHALL cover: pipe_we_i=1, rd=5, data=0xA5A5A5A5, FIFO empty -> next cycle rf_we_o=1, rf_rd_o=5, rf_data_o=0xA5A5A5A5, pipe_stall_o=0.
REQ-034 SHALL cover: mc push rd=7 data=0x1234 while pipe idle -> rf write rd=7 one cycle after push edge; count returns 0.
REQ-035 SHALL cover: FIFO holds rd=9, pipe_we_i=1 every cycle, STARVE_MAX=4 -> pipe wins 4 cycles, 5th cycle pipe_stall_o=1 and rd=9 written; pipe write then completes next cycle.
REQ-036 SHALL cover: push 3 results with DEPTH=2 and pipe busy (no starvation) -> mc_ready_o=0 at count 2, third held until pop; all written in push order.
REQ-037 SHALL cover: pipe rd=0 and FIFO head rd=0 -> no rf_we_o assertion; FIFO head popped; pipe_stall_o=0.
REQ-038 SHALL cover: rst_n low with count=2 mid-stream -> rf_we_o=0 immediately, count=0, no writes after release.
